// File: rtl/serial_adder_seq.sv
// Bit-serial adder: feeds full_adder LSB-first, one bit pair per clock; optional SERIAL_ADDER_OVF_EN adds out_overflow.
// Latency: start at edge 0, busy cycles 1..WIDTH, out_done pulse in cycle WIDTH+1.
// Backpressure: none; in_start is honoured only in IDLE, otherwise dropped.

module full_adder (
   input  logic in_bit1,
   input  logic in_bit2,
   input  logic in_carry,
   output logic out_sum,
   output logic out_carry
);
   assign out_sum   = in_bit1 ^ in_bit2 ^ in_carry;
   assign out_carry = (in_bit1 & in_bit2) | (in_carry & (in_bit1 ^ in_bit2));
endmodule

module serial_adder_seq #(
   parameter int WIDTH = 8
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic             in_start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_carry,
   output logic             out_busy,
   output logic             out_done,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             out_overflow
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
   logic             c_reg;
   logic [CW-1:0]    cnt;
   logic             fa_sum, fa_carry;
   logic             last_bit;

   assign last_bit = (cnt == CW'(WIDTH - 1));

   full_adder u_fa (
      .in_bit1  (a_sh[0]),
      .in_bit2  (b_sh[0]),
      .in_carry (c_reg),
      .out_sum  (fa_sum),
      .out_carry(fa_carry)
   );

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      out_busy  = 1'b0;
      out_done  = 1'b0;
      case (state)
         IDLE:  if (in_start) state_nxt = SHIFT;
         SHIFT: begin
            out_busy = 1'b1;
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            out_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         a_sh      <= '0;
         b_sh      <= '0;
         sum_sh    <= '0;
         c_reg     <= 1'b0;
         cnt       <= '0;
         out_sum   <= '0;
         out_carry <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         out_overflow <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_start) begin
               a_sh   <= in_a;
               b_sh   <= in_b;
               c_reg  <= in_carry;
               cnt    <= '0;
               sum_sh <= '0;
            end
            SHIFT: begin
               sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
               c_reg  <= fa_carry;
               a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
               cnt    <= cnt + 1'b1;
               if (last_bit) begin
                  out_sum   <= {fa_sum, sum_sh[WIDTH-1:1]};
                  out_carry <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                  // c_reg here is the carry into the MSB
                  out_overflow <= c_reg ^ fa_carry;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Randomised bench for serial_adder_seq against a plain-arithmetic model.
module tb_serial_adder_seq;

   localparam int WIDTH = 8;

   logic             in_clk = 1'b0;
   logic             in_rst_n = 1'b0;
   logic             in_start = 1'b0;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic             in_carry = 1'b0;
   logic             out_busy, out_done, out_carry;
   logic [WIDTH-1:0] out_sum;
`ifdef SERIAL_ADDER_OVF_EN
   logic             out_overflow;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [WIDTH-1:0] prev_sum = '0;
   logic             prev_carry = 1'b0;

   serial_adder_seq #(.WIDTH(WIDTH)) dut (
      .in_clk   (in_clk),
      .in_rst_n (in_rst_n),
      .in_start (in_start),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_carry (in_carry),
      .out_busy (out_busy),
      .out_done (out_done),
      .out_sum  (out_sum),
      .out_carry(out_carry)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .out_overflow(out_overflow)
`endif
   );

   always #5 in_clk = ~in_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   // Drive a start for one edge; afterwards scramble operands to prove they were captured.
   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
      in_a = a; in_b = b; in_carry = c; in_start = 1'b1;
      tick();
      in_start = 1'b0;
      in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_carry = 1'($urandom);
   endtask

   // Called in cycle lat0 of an op; waits for out_done and checks the result.
   task automatic finish_op(input int lat0, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic c);
      logic [WIDTH:0] full;
      int lat = lat0;
      int busy_cnt = 0;
      full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
      while (!out_done && lat < 40) begin
         if (out_busy) busy_cnt++;
         tick();
         lat++;
      end
      chk("done_latency", lat, WIDTH + 1);
      chk("busy_cycles", busy_cnt, WIDTH + 1 - lat0);
      chk("busy_in_done", out_busy, 0);
      chk("sum", out_sum, full[WIDTH-1:0]);
      chk("carry", out_carry, full[WIDTH]);
`ifdef SERIAL_ADDER_OVF_EN
      chk("overflow", out_overflow,
          (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]));
`endif
      prev_sum = full[WIDTH-1:0];
      prev_carry = full[WIDTH];
      tick();
      chk("done_width", out_done, 0);
   endtask

   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
      start_op(a, b, c);
      chk("busy_cycle1", out_busy, 1);
      chk("sum_held", out_sum, prev_sum);
      chk("carry_held", out_carry, prev_carry);
      finish_op(1, a, b, c);
   endtask

   initial begin
      logic [WIDTH:0] full;
      int done_at[$];
      logic [WIDTH-1:0] ha, hb;

      #12;
      chk("rst_busy", out_busy, 0);
      chk("rst_done", out_done, 0);
      chk("rst_sum", out_sum, 0);
      chk("rst_carry", out_carry, 0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("rst_ovf", out_overflow, 0);
`endif
      in_rst_n = 1'b1;
      tick();

      run_op(8'h5A, 8'h3C, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b1);
      run_op(8'h7F, 8'h01, 1'b0);
      run_op(8'h80, 8'h80, 1'b0);
      run_op(8'h10, 8'h10, 1'b0);

      // Start request while shifting must be dropped
      start_op(8'h10, 8'h20, 1'b0);
      tick(); tick(); tick();
      in_a = 8'hAA; in_b = 8'h55; in_start = 1'b1;
      tick();
      in_start = 1'b0;
      finish_op(5, 8'h10, 8'h20, 1'b0);
      run_op(8'hAA, 8'h55, 1'b0);

      for (int i = 0; i < 25; i++)
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));

      // Held start: ops should restart every WIDTH+2 cycles
      ha = WIDTH'($urandom); hb = WIDTH'($urandom);
      full = {1'b0, ha} + {1'b0, hb} + 1'b1;
      in_a = ha; in_b = hb; in_carry = 1'b1; in_start = 1'b1;
      for (int t = 0; t < 36; t++) begin
         tick();
         if (out_done) begin
            done_at.push_back(t);
            chk("hold_sum", out_sum, full[WIDTH-1:0]);
            chk("hold_carry", out_carry, full[WIDTH]);
         end
      end
      in_start = 1'b0;
      chk("hold_count", done_at.size(), 3);
      for (int k = 1; k < done_at.size(); k++)
         chk("hold_spacing", done_at[k] - done_at[k-1], WIDTH + 2);
      for (int t = 0; t < 12; t++) tick();
      prev_sum = full[WIDTH-1:0];
      prev_carry = full[WIDTH];

      // Reset in mid-op aborts and clears the outputs immediately
      start_op(8'h7F, 8'h01, 1'b0);
      tick(); tick(); tick(); tick();
      in_rst_n = 1'b0;
      #1;
      chk("abort_busy", out_busy, 0);
      chk("abort_sum", out_sum, 0);
      chk("abort_carry", out_carry, 0);
      for (int t = 0; t < 2; t++) begin
         tick();
         chk("abort_done", out_done, 0);
      end
      in_rst_n = 1'b1;
      prev_sum = '0;
      prev_carry = 1'b0;
      for (int t = 0; t < 12; t++) begin
         tick();
         chk("abort_no_done", out_done, 0);
      end
      run_op(8'h01, 8'h01, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
Bit-serial adder sequencer that drives the existing full_adder cell one bit per clock. It accepts two WIDTH-bit operands and a carry-in, then feeds LSB-first bit pairs to the cell. The cell's carry is registered back into the next bit, and the sum bits are assembled into a parallel result. It sits directly upstream and downstream of full_adder: it produces in_bit1, in_bit2 and in_carry, and consumes out_sum and out_carry.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)

Ports:
in_clk  input  1  system clock, rising edge
in_rst_n  input  1  asynchronous active-low reset
in_start  input  1  start request, sampled in IDLE only
in_a  input  WIDTH  operand A, captured when start accepted
in_b  input  WIDTH  operand B, captured when start accepted
in_carry  input  1  carry-in, captured when start accepted
out_busy  output  1  high while in SHIFT
out_done  output  1  one-cycle pulse, result valid
out_sum  output  WIDTH  result sum, held until next accepted start
out_carry  output  1  final carry-out, held with out_sum

Behaviour:
- Reset: one clock (in_clk); reset is asynchronous and active-low (in_rst_n). Asserting in_rst_n low immediately forces the following, independent of clock:
  - state=IDLE
  - out_busy=0, out_done=0, out_sum=0, out_carry=0
  - operand shift regs, carry reg and bit counter all 0
- full_adder instance connections:
  - in_bit1=a_sh[0], in_bit2=b_sh[0], in_carry=c_reg
  - out_sum and out_carry are consumed inside this block only
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with in_start=1: a_sh<=in_a, b_sh<=in_b, c_reg<=in_carry, cnt<=0, sum_sh<=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (out_busy=1), every edge:
  - sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]}
  - c_reg <= fa_carry
  - a_sh and b_sh shift right by 1 with zero fill
  - cnt <= cnt+1
  - When cnt==WIDTH-1 on this edge: out_sum <= {fa_sum, sum_sh[WIDTH-1:1]}, out_carry <= fa_carry, go to DONE.
- DONE: out_done=1 for exactly one cycle, out_busy=0, unconditional return to IDLE.
- Latency: start sampled at edge 0; SHIFT occupies cycles 1..WIDTH; out_done is high in cycle WIDTH+1. Back-to-back ops are therefore spaced WIDTH+2 cycles apart.
- in_start is ignored in SHIFT and DONE. No queuing: the request is dropped, not deferred.
- in_a, in_b and in_carry may change freely after acceptance without affecting the running op.
- out_sum and out_carry update only on the final SHIFT edge and otherwise hold. They are not cleared by a new start.
- Counter width is clog2(WIDTH)+1; it never wraps within an op.
- Reset mid-SHIFT aborts the op: no out_done pulse, outputs cleared to 0.
- Arithmetic: {out_carry,out_sum} = in_a + in_b + in_carry, unsigned, modulo 2^(WIDTH+1).

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds port out_overflow (output, 1), the signed overflow of the result.
  - On the final SHIFT edge, out_overflow <= c_reg XOR fa_carry (carry into MSB xor carry out of MSB).
  - Reset value 0; held alongside out_sum.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then in_a=0x5A, in_b=0x3C, in_carry=0, start pulse at edge 0 -> out_busy high for cycles 1-8; out_done pulse in cycle 9; out_sum=0x96, out_carry=0.
- in_a=0xFF, in_b=0x01, in_carry=0 -> out_sum=0x00, out_carry=1. Then in_a=0xFF, in_b=0xFF, in_carry=1 -> out_sum=0xFF, out_carry=1.
- Start 0x10+0x20, then pulse in_start with 0xAA/0x55 at cycle 4 -> second request ignored; single out_done; out_sum=0x30. A new start at cycle 10 is accepted.
- Start 0x7F+0x01, deassert in_rst_n at cycle 5 -> immediate out_busy=0, out_sum=0, out_carry=0; no out_done. After release, 0x01+0x01 -> out_sum=0x02.
- With SERIAL_ADDER_OVF_EN: 0x7F+0x01 -> out_sum=0x80, out_overflow=1. 0x80+0x80 -> out_sum=0x00, out_carry=1, out_overflow=1. 0x10+0x10 -> out_overflow=0.
- Hold in_start=1 continuously -> ops restart every 10 cycles (WIDTH=8). out_done pulses are each exactly 1 cycle wide.
